game_ctrl: RTL and testbench

- Game-flow controller and score keeper for pong. Sits directly upstream of the state/score overlay stage.
- Produces the 2-bit game state and both 4-bit player scores that the overlay renders as MENU / GAME OVER / PLAYER n WINS.
- Also produces the ball hold/serve controls consumed by the ball mover.
- Runs on the pixel clock; timing is derived from VGA frame ticks (vblnk rising edge).

---
 rtl/vga_pkg.sv | 15 +
 rtl/edge_sync.sv | 44 ++++
 rtl/game_ctrl.sv | 129 ++++++++++++
 tb/tb_game_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA/pong definitions: game state encoding seen by the overlay stage
// and the default winning score.
package vga_pkg;

    // Overlay compares against menu_start and game_over, so these codes are fixed.
    typedef enum logic [1:0] {
        menu_start = 2'd0,
        play       = 2'd1,
        serve      = 2'd2,
        game_over  = 2'd3
    } game_state_t;

    localparam logic [3:0] WIN_SCORE_DEF = 4'd9;

endpackage

// File: rtl/edge_sync.sv
// Optional N-stage synchroniser followed by a registered-history rising-edge
// detector; SYNC_STAGES=0 gives edge detection only.
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;
    logic sig_prev;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign sig_q = sig;
        end else begin : g_chain
            logic [SYNC_STAGES-1:0] chain;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    chain <= '0;
                end else begin
                    chain[0] <= sig;
                    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end
            assign sig_q = chain[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            sig_prev <= 1'b0;
        end else begin
            sig_prev <= sig_q;
        end
    end

    assign rise = sig_q & ~sig_prev;

endmodule

// File: rtl/game_ctrl.sv
// Pong game-flow controller: menu/serve/play/game-over sequencing, score
// keeping and ball hold/serve control, timed in VGA frames.
module game_ctrl
    import vga_pkg::*;
#(
    parameter logic [3:0]  WIN_SCORE    = WIN_SCORE_DEF,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned OVER_FRAMES  = 180,
    parameter int unsigned FCNT_W       = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vblnk,
    input  logic       start_btn,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [1:0] state,
    output logic [3:0] player1_score,
    output logic [3:0] player2_score,
    output logic       ball_hold,
    output logic       serve_dir,
    output logic       score_evt
);

    localparam logic [FCNT_W-1:0] SERVE_LAST = FCNT_W'(SERVE_FRAMES - 1);
    localparam logic [FCNT_W-1:0] OVER_LAST  = FCNT_W'(OVER_FRAMES - 1);

    game_state_t       state_q;
    logic [FCNT_W-1:0] fcnt;
    logic              start_rise;
    logic              frame_tick;
    logic [3:0]        p1_inc;
    logic [3:0]        p2_inc;

    edge_sync #(.SYNC_STAGES(2)) u_start_sync (
        .clk  (clk),
        .rst  (rst),
        .sig  (start_btn),
        .rise (start_rise)
    );

    edge_sync #(.SYNC_STAGES(0)) u_vblnk_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (vblnk),
        .rise (frame_tick)
    );

    always_comb begin
        p1_inc = player1_score + 4'd1;
        p2_inc = player2_score + 4'd1;
    end

    // ball_hold is assigned alongside every transition so it tracks the new state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= menu_start;
            player1_score <= '0;
            player2_score <= '0;
            ball_hold     <= 1'b1;
            serve_dir     <= 1'b0;
            score_evt     <= 1'b0;
            fcnt          <= '0;
        end else begin
            score_evt <= 1'b0;
            case (state_q)
                menu_start: begin
                    ball_hold <= 1'b1;
                    if (start_rise) begin
                        player1_score <= '0;
                        player2_score <= '0;
                        serve_dir     <= 1'b0;
                        fcnt          <= '0;
                        state_q       <= serve;
                    end
                end
                serve: begin
                    ball_hold <= 1'b1;
                    if (frame_tick) begin
                        if (fcnt == SERVE_LAST) begin
                            fcnt      <= '0;
                            ball_hold <= 1'b0;
                            state_q   <= play;
                        end else begin
                            fcnt <= fcnt + FCNT_W'(1);
                        end
                    end
                end
                play: begin
                    ball_hold <= 1'b0;
                    fcnt      <= '0;
                    if (miss_left && miss_right) begin
                        ball_hold <= 1'b1;
                        state_q   <= serve;
                    end else if (miss_right) begin
                        player1_score <= p1_inc;
                        serve_dir     <= 1'b1;
                        score_evt     <= 1'b1;
                        ball_hold     <= 1'b1;
                        state_q       <= (p1_inc == WIN_SCORE) ? game_over : serve;
                    end else if (miss_left) begin
                        player2_score <= p2_inc;
                        serve_dir     <= 1'b0;
                        score_evt     <= 1'b1;
                        ball_hold     <= 1'b1;
                        state_q       <= (p2_inc == WIN_SCORE) ? game_over : serve;
                    end
                end
                game_over: begin
                    ball_hold <= 1'b1;
                    if (start_rise && fcnt == OVER_LAST) begin
                        fcnt    <= '0;
                        state_q <= menu_start;
                    end else if (frame_tick && fcnt != OVER_LAST) begin
                        fcnt <= fcnt + FCNT_W'(1);
                    end
                end
                default: begin
                    ball_hold <= 1'b1;
                    fcnt      <= '0;
                    state_q   <= menu_start;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed vector table, a hand-written reset corner
// and randomized stimulus against a frame/point-level reference model.
module tb_game_ctrl;

    localparam logic [3:0]  WIN   = 4'd3;
    localparam int unsigned SERVE = 3;
    localparam int unsigned OVER  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vblnk = 1'b0;
    logic       start_btn = 1'b0;
    logic       miss_left = 1'b0;
    logic       miss_right = 1'b0;
    logic [1:0] state;
    logic [3:0] player1_score;
    logic [3:0] player2_score;
    logic       ball_hold;
    logic       serve_dir;
    logic       score_evt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    game_ctrl #(
        .WIN_SCORE    (WIN),
        .SERVE_FRAMES (SERVE),
        .OVER_FRAMES  (OVER),
        .FCNT_W       (9)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vblnk         (vblnk),
        .start_btn     (start_btn),
        .miss_left     (miss_left),
        .miss_right    (miss_right),
        .state         (state),
        .player1_score (player1_score),
        .player2_score (player2_score),
        .ball_hold     (ball_hold),
        .serve_dir     (serve_dir),
        .score_evt     (score_evt)
    );

    // Reference model: mode 0 menu, 1 play, 2 serve, 3 over; ticks counts frames seen.
    int m_mode, m_p1, m_p2, m_dir, m_evt, m_ticks;
    bit st_h[3];
    bit vb_prev;

    task automatic model_edge(input bit r, input bit st, input bit vb, input bit ml, input bit mr);
        bit rise, tick;
        if (!r) begin
            m_mode = 0; m_p1 = 0; m_p2 = 0; m_dir = 0; m_evt = 0; m_ticks = 0;
            st_h = '{1'b0, 1'b0, 1'b0};
            vb_prev = 1'b0;
            return;
        end
        // Button seen two samples late through the synchroniser.
        rise = st_h[1] & ~st_h[2];
        tick = vb & ~vb_prev;
        m_evt = 0;
        case (m_mode)
            0: if (rise) begin
                m_p1 = 0; m_p2 = 0; m_dir = 0; m_ticks = 0; m_mode = 2;
            end
            2: if (tick) begin
                m_ticks++;
                if (m_ticks == SERVE) begin m_mode = 1; m_ticks = 0; end
            end
            1: begin
                if (ml && mr) begin
                    m_mode = 2; m_ticks = 0;
                end else if (mr) begin
                    m_p1++; m_dir = 1; m_evt = 1; m_ticks = 0;
                    m_mode = (m_p1 == WIN) ? 3 : 2;
                end else if (ml) begin
                    m_p2++; m_dir = 0; m_evt = 1; m_ticks = 0;
                    m_mode = (m_p2 == WIN) ? 3 : 2;
                end
            end
            default: begin
                if (rise && m_ticks >= OVER - 1) begin
                    m_mode = 0; m_ticks = 0;
                end else if (tick && m_ticks < OVER - 1) begin
                    m_ticks++;
                end
            end
        endcase
        st_h[2] = st_h[1];
        st_h[1] = st_h[0];
        st_h[0] = st;
        vb_prev = vb;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".state"}, int'(state), m_mode);
        chk({tag, ".p1"}, int'(player1_score), m_p1);
        chk({tag, ".p2"}, int'(player2_score), m_p2);
        chk({tag, ".hold"}, int'(ball_hold), (m_mode != 1) ? 1 : 0);
        chk({tag, ".dir"}, int'(serve_dir), m_dir);
        chk({tag, ".evt"}, int'(score_evt), m_evt);
    endtask

    // Drive one cycle of inputs, clock it, step the model; outputs sampled #1 after the edge.
    task automatic step(input bit r, input bit st, input bit vb, input bit ml, input bit mr);
        rst = r; start_btn = st; vblnk = vb; miss_left = ml; miss_right = mr;
        @(posedge clk);
        #1;
        model_edge(r, st, vb, ml, mr);
    endtask

    typedef struct {
        bit       r, st, vb, ml, mr;
        int       e_state, e_p1, e_p2, e_hold, e_dir, e_evt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input bit st, input bit vb, input bit ml, input bit mr,
                                input int es, input int ep1, input int ep2, input int eh,
                                input int ed, input int ee);
        vec_t v;
        v.r = r; v.st = st; v.vb = vb; v.ml = ml; v.mr = mr;
        v.e_state = es; v.e_p1 = ep1; v.e_p2 = ep2; v.e_hold = eh; v.e_dir = ed; v.e_evt = ee;
        tbl.push_back(v);
    endfunction

    // Three frame ticks in serve (alternating vblnk), landing in play on the last one.
    function automatic void add_serve(input int p1, input int p2, input int d);
        add(1, 0, 1, 0, 0, 2, p1, p2, 1, d, 0);
        add(1, 0, 0, 0, 0, 2, p1, p2, 1, d, 0);
        add(1, 0, 1, 0, 0, 2, p1, p2, 1, d, 0);
        add(1, 0, 0, 0, 0, 2, p1, p2, 1, d, 0);
        add(1, 0, 1, 0, 0, 1, p1, p2, 0, d, 0);
    endfunction

    task automatic serve_to_play();
        step(1, 0, 1, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        chk_model("hand.serve");
    endtask

    initial begin
        bit st_r, vb_r;

        //  r st vb ml mr | state p1 p2 hold dir evt
        add(0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0,  0, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0,  2, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0,  2, 0, 0, 1, 0, 0);
        add(1, 1, 0, 0, 0,  2, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0,  2, 0, 0, 1, 0, 0);
        add_serve(0, 0, 0);
        add(1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0,  1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1,  2, 1, 0, 1, 1, 1);
        add(1, 0, 0, 1, 0,  2, 1, 0, 1, 1, 0);
        add_serve(1, 0, 1);
        add(1, 0, 0, 1, 1,  2, 1, 0, 1, 1, 0);
        add_serve(1, 0, 1);
        add(1, 0, 0, 1, 0,  2, 1, 1, 1, 0, 1);
        add_serve(1, 1, 0);
        add(1, 0, 0, 1, 0,  2, 1, 2, 1, 0, 1);
        add_serve(1, 2, 0);
        add(1, 0, 0, 1, 0,  3, 1, 3, 1, 0, 1);
        add(1, 1, 1, 0, 0,  3, 1, 3, 1, 0, 0);
        add(1, 1, 0, 0, 0,  3, 1, 3, 1, 0, 0);
        add(1, 1, 1, 0, 0,  3, 1, 3, 1, 0, 0);
        add(1, 0, 0, 0, 0,  3, 1, 3, 1, 0, 0);
        add(1, 0, 1, 0, 0,  3, 1, 3, 1, 0, 0);
        add(1, 0, 0, 0, 0,  3, 1, 3, 1, 0, 0);
        add(1, 0, 1, 0, 0,  3, 1, 3, 1, 0, 0);
        add(1, 1, 0, 0, 0,  3, 1, 3, 1, 0, 0);
        add(1, 1, 0, 0, 0,  3, 1, 3, 1, 0, 0);
        add(1, 1, 0, 0, 0,  0, 1, 3, 1, 0, 0);
        add(1, 0, 0, 0, 0,  0, 1, 3, 1, 0, 0);
        add(1, 0, 0, 0, 0,  0, 1, 3, 1, 0, 0);
        add(1, 1, 0, 0, 0,  0, 1, 3, 1, 0, 0);
        add(1, 1, 0, 0, 0,  0, 1, 3, 1, 0, 0);
        add(1, 1, 0, 0, 0,  2, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0,  2, 0, 0, 1, 0, 0);

        model_edge(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].st, tbl[i].vb, tbl[i].ml, tbl[i].mr);
            chk($sformatf("vec%0d.state", i), int'(state), tbl[i].e_state);
            chk($sformatf("vec%0d.p1", i), int'(player1_score), tbl[i].e_p1);
            chk($sformatf("vec%0d.p2", i), int'(player2_score), tbl[i].e_p2);
            chk($sformatf("vec%0d.hold", i), int'(ball_hold), tbl[i].e_hold);
            chk($sformatf("vec%0d.dir", i), int'(serve_dir), tbl[i].e_dir);
            chk($sformatf("vec%0d.evt", i), int'(score_evt), tbl[i].e_evt);
            chk_model($sformatf("vec%0d.model", i));
        end

        // Reach play at 2/1, then reset in the middle of a miss pulse.
        serve_to_play();
        step(1, 0, 0, 0, 1);
        serve_to_play();
        step(1, 0, 0, 0, 1);
        serve_to_play();
        step(1, 0, 0, 1, 0);
        serve_to_play();
        chk("mid.state", int'(state), 1);
        chk("mid.p1", int'(player1_score), 2);
        chk("mid.p2", int'(player2_score), 1);
        step(0, 0, 0, 0, 1);
        chk("rst.state", int'(state), 0);
        chk("rst.p1", int'(player1_score), 0);
        chk("rst.p2", int'(player2_score), 0);
        chk("rst.hold", int'(ball_hold), 1);
        chk("rst.evt", int'(score_evt), 0);
        chk("rst.dir", int'(serve_dir), 0);

        // Randomized run against the model.
        st_r = 1'b0;
        vb_r = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 19) == 0) st_r = ~st_r;
            if ($urandom_range(0, 1) == 0) vb_r = ~vb_r;
            step(($urandom_range(0, 599) != 0), st_r, vb_r,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
            chk_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
